// File: rtl/full_sub_pkg.sv
// Shared definitions for the full_sub ripple-borrow subtractor: default
// width and the per-bit difference/borrow equations used by the 1-bit cell.
package full_sub_pkg;

    localparam int unsigned FS_DEFAULT_WIDTH = 32'd1;

    // Difference bit of a single full-subtractor stage.
    function automatic logic fs_diff_bit(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow-out of a single full-subtractor stage: borrow whenever the
    // subtrahend plus incoming borrow exceeds the minuend bit.
    function automatic logic fs_borrow_bit(input logic a, input logic b, input logic bin);
        return (~a & b) | (~a & bin) | (b & bin);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Purely combinational 1-bit full subtractor cell (a - b - bin).
module full_sub_cell
    import full_sub_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = fs_diff_bit(a_i, b_i, bin_i);
    assign bout_o = fs_borrow_bit(a_i, b_i, bin_i);

endmodule

// File: rtl/full_sub.sv
// Registered WIDTH-bit full subtractor: {borrow, diff} = a - b - cin,
// built as a ripple-borrow chain of 1-bit cells with a one-cycle output
// register stage. Outputs hold their last result while in_valid is low.
module full_sub
    import full_sub_pkg::*;
#(
    parameter int unsigned WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Borrow chain: bin_s[0] is the external borrow-in, bin_s[WIDTH] the MSB borrow-out.
    logic [WIDTH:0]   bin_s;
    logic [WIDTH-1:0] d_s;

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] diff_d,  diff_q;
    logic             borrow_d, borrow_q;

    assign bin_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_sub_cell u_cell (
            .a_i    (a[i]),
            .b_i    (b[i]),
            .bin_i  (bin_s[i]),
            .d_o    (d_s[i]),
            .bout_o (bin_s[i+1])
        );
    end

    // Next-state: capture a new result only on valid input, otherwise hold,
    // so undefined operands during idle cycles never reach the outputs.
    always_comb begin
        valid_d  = in_valid;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (in_valid) begin
            diff_d   = d_s;
            borrow_d = bin_s[WIDTH];
        end else begin
            diff_d   = diff_q;
            borrow_d = borrow_q;
        end
    end

    // Output register stage; synchronous reset wins over any incoming valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign out_valid = valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_full_sub.sv
// Self-checking bench for full_sub: a 1-bit and an 8-bit instance share the
// clock and reset. Expected results are pushed to per-instance queues when a
// valid vector is driven and popped when the output register should hold it.
module tb_full_sub;

    logic       clk;
    logic       rst;
    logic       v1, c1, ov1, d1, br1;
    logic [0:0] a1, b1, diff1;
    logic       v8, c8, ov8, br8;
    logic [7:0] a8, b8, diff8;

    int checks   = 0;
    int failures = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [1:0] hold1;
    logic [8:0] hold8;

    full_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .diff(diff1), .borrow(br1)
    );

    full_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .diff(diff8), .borrow(br8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word subtraction in WIDTH+1 bits, result {borrow, diff}.
    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = {1'b0, a} - {1'b0, b} - {1'b0, c};
        return t;
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} - {1'b0, b} - {8'd0, c};
        return t;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive both instances before the edge, check just after it.
    task automatic step(input logic r,
                        input logic vv1, input logic aa1, input logic bb1, input logic cc1,
                        input logic vv8, input logic [7:0] aa8, input logic [7:0] bb8, input logic cc8);
        @(negedge clk);
        rst = r;
        v1 = vv1; a1 = aa1; b1 = bb1; c1 = cc1;
        v8 = vv8; a8 = aa8; b8 = bb8; c8 = cc8;
        if (!r && vv1) q1.push_back(ref1(aa1, bb1, cc1));
        if (!r && vv8) q8.push_back(ref8(aa8, bb8, cc8));
        @(posedge clk);
        #1;
        if (r) begin
            hold1 = 2'b00;
            hold8 = 9'd0;
            chk("rst_valid1", {8'd0, ov1}, 9'd0);
            chk("rst_valid8", {8'd0, ov8}, 9'd0);
        end else begin
            chk("valid1", {8'd0, ov1}, {8'd0, vv1});
            chk("valid8", {8'd0, ov8}, {8'd0, vv8});
            if (vv1) begin
                if (q1.size() == 0) chk("q1_empty", 9'd1, 9'd0);
                else hold1 = q1.pop_front();
            end else begin
                hold1 = hold1;
            end
            if (vv8) begin
                if (q8.size() == 0) chk("q8_empty", 9'd1, 9'd0);
                else hold8 = q8.pop_front();
            end else begin
                hold8 = hold8;
            end
        end
        chk("res1", {7'd0, br1, diff1}, {7'd0, hold1});
        chk("res8", {br8, diff8}, hold8);
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
        hold1 = 2'b00;
        hold8 = 9'd0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // WIDTH=1 exhaustive, back-to-back; WIDTH=8 directed arithmetic/wrap alongside.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h50, 8'h20, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h50, 8'h20, 1'b0);

        // Valid gating: outputs hold 0x30/0 while random operands are presented.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Reset concurrent with a valid vector: result is discarded.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 1'b0);

        // Reset, then valid on the very first edge after release.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);

        // Throughput: 16 random back-to-back vectors.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        chk("q1_drained", {3'd0, 6'(q1.size())}, 9'd0);
        chk("q8_drained", {3'd0, 6'(q8.size())}, 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
